// File: rtl/stereo_sad_disparity.sv
// Stereo matcher: RGB->luma, per-disparity horizontal SAD window, pipelined argmin tree.
// Optional feature macro: STEREO_UNIQUENESS_EN (ambiguous matches report oDisp = 8'hFF).
module stereo_sad_disparity #(
  parameter int MAX_DISP    = 16,
  parameter int WIN         = 5,
  parameter int X_START     = 45,
  parameter int X_END       = 684,
  parameter int Y_START     = 45,
  parameter int Y_END       = 524,
  parameter int UNIQ_MARGIN = 4
) (
  input  logic        rdClk,
  input  logic        RST,
  input  logic [7:0]  aR,
  input  logic [7:0]  aG,
  input  logic [7:0]  aB,
  input  logic [7:0]  bR,
  input  logic [7:0]  bG,
  input  logic [7:0]  bB,
  input  logic [15:0] iX,
  input  logic [15:0] iY,
  output logic [7:0]  oDisp,
  output logic        oValid,
  output logic [15:0] oX,
  output logic [15:0] oY
);
  // Streaming contract: no back-pressure. One sample enters and one result leaves every rdClk;
  // oValid qualifies oDisp/oX/oY on the same cycle and there is no ready signal.
  localparam int LEVELS = $clog2(MAX_DISP);
  localparam int CW     = 8 + $clog2(WIN);
  localparam int FILL   = MAX_DISP + WIN - 2;
  localparam int NW     = $clog2(FILL + 1);
  localparam int HALF   = MAX_DISP / 2;

  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [15:0] s;
    s = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
    return 8'(s >> 8);
  endfunction

  // Stage 1: luma, line-start detection, fill counter (saturates once the sample is fully valid)
  logic          active, first, armed;
  logic [NW-1:0] nCnt, nCur;
  logic [7:0]    lumaL1, lumaR1;
  logic          first1, val1;
  logic [15:0]   x1, y1;

  assign active = (iX >= 16'(X_START)) && (iX <= 16'(X_END)) &&
                  (iY >= 16'(Y_START)) && (iY <= 16'(Y_END));
  assign first  = active && (iX == 16'(X_START));
  assign nCur   = first ? '0 : nCnt;

  always_ff @(posedge rdClk) begin
    if (RST) begin
      lumaL1 <= '0;
      lumaR1 <= '0;
      first1 <= 1'b0;
      val1   <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      nCnt   <= '0;
      armed  <= 1'b0;
    end else begin
      lumaL1 <= luma(aR, aG, aB);
      lumaR1 <= luma(bR, bG, bB);
      first1 <= first;
      val1   <= active && (first || armed) && (nCur == NW'(FILL));
      x1     <= iX - 16'((WIN - 1) / 2);
      y1     <= iY;
      if (active) begin
        nCnt <= (nCur == NW'(FILL)) ? nCur : nCur + NW'(1);
        if (first) armed <= 1'b1;
      end
    end
  end

  // Stage 2: right history and absolute differences; a line start sees an empty history
  logic [7:0]  hist [MAX_DISP-1];
  logic [7:0]  rDel [MAX_DISP];
  logic [7:0]  adNext [MAX_DISP];
  logic [7:0]  ad2 [MAX_DISP];
  logic        first2, val2;
  logic [15:0] x2, y2;

  always_comb begin
    rDel[0] = lumaR1;
    for (int d = 1; d < MAX_DISP; d++) rDel[d] = first1 ? 8'd0 : hist[d-1];
    for (int d = 0; d < MAX_DISP; d++)
      adNext[d] = (lumaL1 >= rDel[d]) ? lumaL1 - rDel[d] : rDel[d] - lumaL1;
  end

  always_ff @(posedge rdClk) begin
    if (RST) begin
      for (int d = 0; d < MAX_DISP; d++) ad2[d] <= '0;
      for (int k = 0; k < MAX_DISP - 1; k++) hist[k] <= '0;
      first2 <= 1'b0;
      val2   <= 1'b0;
      x2     <= '0;
      y2     <= '0;
    end else begin
      for (int d = 0; d < MAX_DISP; d++) ad2[d] <= adNext[d];
      hist[0] <= lumaR1;
      for (int k = 1; k < MAX_DISP - 1; k++) hist[k] <= first1 ? 8'd0 : hist[k-1];
      first2 <= first1;
      val2   <= val1;
      x2     <= x1;
      y2     <= y1;
    end
  end

  // Stage 3: running window sums; remove the leaving term before adding so nothing overflows
  logic [7:0]    dline [MAX_DISP][WIN];
  logic [CW-1:0] cost3 [MAX_DISP];
  logic [CW-1:0] costNext [MAX_DISP];
  logic          val3;
  logic [15:0]   x3, y3;

  always_comb begin
    for (int d = 0; d < MAX_DISP; d++)
      costNext[d] = (first2 ? '0 : cost3[d] - CW'(dline[d][WIN-1])) + CW'(ad2[d]);
  end

  always_ff @(posedge rdClk) begin
    if (RST) begin
      for (int d = 0; d < MAX_DISP; d++) begin
        cost3[d] <= '0;
        for (int k = 0; k < WIN; k++) dline[d][k] <= '0;
      end
      val3 <= 1'b0;
      x3   <= '0;
      y3   <= '0;
    end else begin
      for (int d = 0; d < MAX_DISP; d++) begin
        cost3[d]    <= costNext[d];
        dline[d][0] <= ad2[d];
        for (int k = 1; k < WIN; k++) dline[d][k] <= first2 ? 8'd0 : dline[d][k-1];
      end
      val3 <= val2;
      x3   <= x2;
      y3   <= y2;
    end
  end

  // Argmin tree: the left (lower-index) operand wins ties, so the lowest disparity survives
  logic [CW-1:0]     tCost [LEVELS][HALF];
  logic [CW-1:0]     nCost [LEVELS][HALF];
  logic [LEVELS-1:0] tIdx  [LEVELS][HALF];
  logic [LEVELS-1:0] nIdx  [LEVELS][HALF];
  logic [CW-1:0]     ca, cb;
  logic [LEVELS-1:0] ia, ib;
`ifdef STEREO_UNIQUENESS_EN
  logic [CW-1:0]     tSec [LEVELS][HALF];
  logic [CW-1:0]     nSec [LEVELS][HALF];
  logic [CW-1:0]     sa, sb;
`endif
  logic              vSh [LEVELS];
  logic [15:0]       xSh [LEVELS];
  logic [15:0]       ySh [LEVELS];
  logic [7:0]        dispR;

  always_comb begin
    ca = '0;
    cb = '0;
    ia = '0;
    ib = '0;
`ifdef STEREO_UNIQUENESS_EN
    sa = '1;
    sb = '1;
`endif
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int k = 0; k < HALF; k++) begin
        nCost[lv][k] = '0;
        nIdx[lv][k]  = '0;
`ifdef STEREO_UNIQUENESS_EN
        nSec[lv][k]  = '0;
`endif
      end
    end
    for (int lv = 0; lv < LEVELS; lv++) begin
      for (int k = 0; k < HALF; k++) begin
        if (k < (MAX_DISP >> (lv + 1))) begin
          if (lv == 0) begin
            ca = cost3[2*k];
            cb = cost3[2*k+1];
            ia = LEVELS'(2*k);
            ib = LEVELS'(2*k+1);
`ifdef STEREO_UNIQUENESS_EN
            sa = '1;
            sb = '1;
`endif
          end else begin
            ca = tCost[lv-1][2*k];
            cb = tCost[lv-1][2*k+1];
            ia = tIdx[lv-1][2*k];
            ib = tIdx[lv-1][2*k+1];
`ifdef STEREO_UNIQUENESS_EN
            sa = tSec[lv-1][2*k];
            sb = tSec[lv-1][2*k+1];
`endif
          end
          if (ca <= cb) begin
            nCost[lv][k] = ca;
            nIdx[lv][k]  = ia;
`ifdef STEREO_UNIQUENESS_EN
            nSec[lv][k]  = (sa < cb) ? sa : cb;
`endif
          end else begin
            nCost[lv][k] = cb;
            nIdx[lv][k]  = ib;
`ifdef STEREO_UNIQUENESS_EN
            nSec[lv][k]  = (ca < sb) ? ca : sb;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge rdClk) begin
    if (RST) begin
      for (int lv = 0; lv < LEVELS; lv++) begin
        for (int k = 0; k < HALF; k++) begin
          tCost[lv][k] <= '0;
          tIdx[lv][k]  <= '0;
`ifdef STEREO_UNIQUENESS_EN
          tSec[lv][k]  <= '0;
`endif
        end
        vSh[lv] <= 1'b0;
        xSh[lv] <= '0;
        ySh[lv] <= '0;
      end
      dispR <= '0;
    end else begin
      for (int lv = 0; lv < LEVELS; lv++) begin
        for (int k = 0; k < HALF; k++) begin
          tCost[lv][k] <= nCost[lv][k];
          tIdx[lv][k]  <= nIdx[lv][k];
`ifdef STEREO_UNIQUENESS_EN
          tSec[lv][k]  <= nSec[lv][k];
`endif
        end
      end
      vSh[0] <= val3;
      xSh[0] <= x3;
      ySh[0] <= y3;
      for (int lv = 1; lv < LEVELS; lv++) begin
        vSh[lv] <= vSh[lv-1];
        xSh[lv] <= xSh[lv-1];
        ySh[lv] <= ySh[lv-1];
      end
`ifdef STEREO_UNIQUENESS_EN
      if ((nSec[LEVELS-1][0] - nCost[LEVELS-1][0]) < CW'(UNIQ_MARGIN)) dispR <= 8'hFF;
      else dispR <= 8'(nIdx[LEVELS-1][0]);
`else
      dispR <= 8'(nIdx[LEVELS-1][0]);
`endif
    end
  end

  assign oDisp  = dispR;
  assign oValid = vSh[LEVELS-1];
  assign oX     = xSh[LEVELS-1];
  assign oY     = ySh[LEVELS-1];

endmodule

// File: tb/tb_stereo_sad_disparity.sv
// Randomized bench for stereo_sad_disparity: per-line luma arrays feed a direct window-sum
// argmin model; expected results wait in a queue for the fixed pipeline latency.
module tb_stereo_sad_disparity;
  localparam int MAX_DISP    = 16;
  localparam int WIN         = 5;
  localparam int X_START     = 45;
  localparam int X_END       = 684;
  localparam int Y_START     = 45;
  localparam int Y_END       = 524;
  localparam int UNIQ_MARGIN = 4;
  localparam int LAT         = 3 + $clog2(MAX_DISP);

  logic        rdClk = 1'b0;
  logic        RST;
  logic [7:0]  aR, aG, aB, bR, bG, bB;
  logic [15:0] iX, iY;
  logic [7:0]  oDisp;
  logic        oValid;
  logic [15:0] oX, oY;

  stereo_sad_disparity #(
    .MAX_DISP(MAX_DISP), .WIN(WIN), .X_START(X_START), .X_END(X_END),
    .Y_START(Y_START), .Y_END(Y_END), .UNIQ_MARGIN(UNIQ_MARGIN)
  ) dut (
    .rdClk(rdClk), .RST(RST),
    .aR(aR), .aG(aG), .aB(aB), .bR(bR), .bG(bG), .bB(bB),
    .iX(iX), .iY(iY),
    .oDisp(oDisp), .oValid(oValid), .oX(oX), .oY(oY)
  );

  // Clock: 25 MHz pixel clock
  always #20 rdClk = ~rdClk;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [40:0] expQ[$];     // {valid, disp[7:0], x[15:0], y[15:0]}
  int          lumaL[1024];
  int          lumaR[1024];
  int          mN = 0;
  bit          mArmed = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_disp"}, 32'(oDisp), 32'd0);
    checkVal({tag, "_valid"}, 32'(oValid), 32'd0);
    checkVal({tag, "_x"}, 32'(oX), 32'd0);
    checkVal({tag, "_y"}, 32'(oY), 32'd0);
  endtask

  // Drive one sample, update the reference model, then compare the output due this cycle
  task automatic stepSample(input logic [7:0] ar, input logic [7:0] ag, input logic [7:0] ab,
                            input logic [7:0] br, input logic [7:0] bg, input logic [7:0] bb,
                            input int x, input int y, input bit rst);
    logic [40:0] e;
    bit          act;
    int          best, sec, bd, c, dl, dr;
    @(negedge rdClk);
    aR = ar; aG = ag; aB = ab;
    bR = br; bG = bg; bB = bb;
    iX = 16'(x);
    iY = 16'(y);
    RST = rst;
    act = (x >= X_START) && (x <= X_END) && (y >= Y_START) && (y <= Y_END);
    e = '0;
    if (rst) begin
      mArmed = 1'b0;
      foreach (expQ[i]) expQ[i][40] = 1'b0;
    end else if (act) begin
      if (x == X_START) begin
        mN = 0;
        mArmed = 1'b1;
      end
      lumaL[mN] = (77 * int'(ar) + 150 * int'(ag) + 29 * int'(ab)) / 256;
      lumaR[mN] = (77 * int'(br) + 150 * int'(bg) + 29 * int'(bb)) / 256;
      if (mArmed && mN >= MAX_DISP + WIN - 2) begin
        best = 1 << 30;
        sec  = 1 << 30;
        bd   = 0;
        for (int d = 0; d < MAX_DISP; d++) begin
          c = 0;
          for (int j = mN - WIN + 1; j <= mN; j++) begin
            dl = lumaL[j];
            dr = lumaR[j-d];
            c += (dl > dr) ? dl - dr : dr - dl;
          end
          if (c < best) begin
            sec  = best;
            best = c;
            bd   = d;
          end else if (c < sec) begin
            sec = c;
          end
        end
        e[40]    = 1'b1;
        e[39:32] = 8'(bd);
`ifdef STEREO_UNIQUENESS_EN
        if (sec - best < UNIQ_MARGIN) e[39:32] = 8'hFF;
`endif
        e[31:16] = 16'(x - (WIN - 1) / 2);
        e[15:0]  = 16'(y);
      end
      if (mN < 1023) mN++;
    end
    expQ.push_back(e);
    @(posedge rdClk);
    #1;
    if (rst) checkResetOutputs("midline_rst");
    if (expQ.size() == LAT) begin
      e = expQ.pop_front();
      checkVal("valid", 32'(oValid), 32'(e[40]));
      if (e[40]) begin
        checkVal("disp", 32'(oDisp), 32'(e[39:32]));
        checkVal("x", 32'(oX), 32'(e[31:16]));
        checkVal("y", 32'(oY), 32'(e[15:0]));
      end
    end
  endtask

  // mode 0: flat grey, 1: texture with right[x] = left[x+5], 2: independent random, 3: low-contrast random
  task automatic runLine(input int y, input int xs, input int xe, input int mode, input int rstX);
    logic [7:0] lr[720], lg[720], lb[720], rr[720], rg[720], rb[720];
    for (int x = 0; x < 720; x++) begin
      case (mode)
        0: begin
          lr[x] = 8'd128; lg[x] = 8'd128; lb[x] = 8'd128;
          rr[x] = 8'd128; rg[x] = 8'd128; rb[x] = 8'd128;
        end
        3: begin
          lr[x] = 8'($urandom_range(0, 3)); lg[x] = 8'($urandom_range(0, 3)); lb[x] = 8'($urandom_range(0, 3));
          rr[x] = 8'($urandom_range(0, 3)); rg[x] = 8'($urandom_range(0, 3)); rb[x] = 8'($urandom_range(0, 3));
        end
        default: begin
          lr[x] = 8'($urandom_range(0, 255)); lg[x] = 8'($urandom_range(0, 255)); lb[x] = 8'($urandom_range(0, 255));
          rr[x] = 8'($urandom_range(0, 255)); rg[x] = 8'($urandom_range(0, 255)); rb[x] = 8'($urandom_range(0, 255));
        end
      endcase
    end
    if (mode == 1) begin
      for (int x = 0; x < 715; x++) begin
        rr[x] = lr[x+5]; rg[x] = lg[x+5]; rb[x] = lb[x+5];
      end
    end
    for (int x = xs; x <= xe; x++)
      stepSample(lr[x], lg[x], lb[x], rr[x], rg[x], rb[x], x, y, x == rstX);
  endtask

  initial begin
    RST = 1'b1;
    aR = '0; aG = '0; aB = '0;
    bR = '0; bG = '0; bB = '0;
    iX = '0; iY = '0;
    repeat (3) @(posedge rdClk);
    #1;
    checkResetOutputs("por_rst");

    runLine(50, 40, 100, 0, -1);                  // flat: all ties -> d = 0
    runLine(51, 40, 160, 1, -1);                  // shifted texture -> d = 5
    runLine(52, X_START, 160, 1, -1);             // back-to-back line start
    runLine(53, 40, X_END + 6, 2, -1);            // full line, past the last active X
    runLine(54, 40, 140, 3, -1);                  // low contrast, frequent ties
    runLine(55, 40, 200, 1, X_START + 100);       // reset pulse at n = 100
    runLine(56, 40, 120, 1, -1);                  // recovery on the next line
    runLine(Y_START - 1, 40, 100, 1, -1);         // inactive line above the window
    runLine(Y_END, 40, 100, 1, -1);               // last active line
    runLine(Y_END + 1, 40, 100, 1, -1);           // first inactive line below
    runLine(0, 0, 12, 0, -1);                     // drain

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
